// File: rtl/reg_branch_unit.sv
// Register increment/decrement and register-conditional branch sequencer.
// Each op walks IDLE -> READ -> EXEC -> DONE; every output is driven from a flop.
module reg_branch_unit #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [1:0]    op,
  input  logic [AW-1:0] op_reg,
  input  logic [2:0]    op_v,
  input  logic [W-1:0]  pc_in,
  output logic          rf_rd_en,
  output logic [AW-1:0] rf_rd_addr,
  input  logic [W-1:0]  rf_rd_data,
  output logic          rf_wr_en,
  output logic [AW-1:0] rf_wr_addr,
  output logic [W-1:0]  rf_wr_data,
  output logic          br_valid,
  output logic          br_taken,
  output logic [W-1:0]  br_target,
  output logic          wrap,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, DONE} state_t;

  localparam logic [1:0] OP_INCR = 2'b00;
  localparam logic [1:0] OP_DECR = 2'b01;
  localparam logic [1:0] OP_JIZR = 2'b10;
  localparam logic [1:0] OP_JNZR = 2'b11;

  state_t        state_reg, state_next;
  logic [1:0]    op_sel_reg;
  logic [AW-1:0] reg_idx_reg;
  logic [2:0]    v_reg;
  logic [W-1:0]  pc_reg;

  logic [W-1:0]  incr_val, decr_val, target_val;
  logic          x_zero, x_ones, accept;
  logic          next_done, next_write, next_branch;

  assign accept      = op_valid && (state_reg == IDLE);
  assign incr_val    = rf_rd_data + W'(1);
  assign decr_val    = rf_rd_data - W'(1);
  assign x_zero      = (rf_rd_data == '0);
  assign x_ones      = &rf_rd_data;
  // Offset is counted in half-words, so it is shifted left by one before the add.
  assign target_val  = pc_reg + W'({v_reg, 1'b0});
  assign next_done   = (state_next == DONE);
  assign next_write  = next_done && !op_sel_reg[1];
  assign next_branch = next_done && op_sel_reg[1];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = READ;
      READ:    state_next = EXEC;
      EXEC:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      op_sel_reg  <= '0;
      reg_idx_reg <= '0;
      v_reg       <= '0;
      pc_reg      <= '0;
      op_ready    <= 1'b1;
      rf_rd_en    <= 1'b0;
      rf_rd_addr  <= '0;
      rf_wr_en    <= 1'b0;
      rf_wr_addr  <= '0;
      rf_wr_data  <= '0;
      br_valid    <= 1'b0;
      br_taken    <= 1'b0;
      br_target   <= '0;
      wrap        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_reg <= state_next;
      op_ready  <= (state_next == IDLE);

      if (accept) begin
        op_sel_reg  <= op;
        reg_idx_reg <= op_reg;
        v_reg       <= op_v;
        pc_reg      <= pc_in;
      end

      // READ is only ever entered straight from IDLE, so the live index is the one to present.
      rf_rd_en   <= (state_next == READ);
      rf_rd_addr <= (state_next == READ) ? op_reg : '0;

      if (state_reg == EXEC) begin
        case (op_sel_reg)
          OP_INCR: begin
            rf_wr_data <= incr_val;
            wrap       <= x_ones;
          end
          OP_DECR: begin
            rf_wr_data <= decr_val;
            wrap       <= x_zero;
          end
          OP_JIZR: begin
            br_taken  <= x_zero;
            br_target <= target_val;
            wrap      <= 1'b0;
          end
          OP_JNZR: begin
            br_taken  <= !x_zero;
            br_target <= target_val;
            wrap      <= 1'b0;
          end
          default: wrap <= 1'b0;
        endcase
      end

      done       <= next_done;
      rf_wr_en   <= next_write;
      rf_wr_addr <= next_write ? reg_idx_reg : '0;
      br_valid   <= next_branch;
    end
  end

endmodule

// File: tb/tb_reg_branch_unit.sv
// Bench for reg_branch_unit: directed vector table, multi-cycle corner sequences,
// and random ops checked against an arithmetic model of the register file.
module tb_reg_branch_unit;

  logic       clk;
  logic       reset;
  logic       op_valid;
  logic       op_ready;
  logic [1:0] op;
  logic [2:0] op_reg;
  logic [2:0] op_v;
  logic [7:0] pc_in;
  logic       rf_rd_en;
  logic [2:0] rf_rd_addr;
  logic [7:0] rf_rd_data;
  logic       rf_wr_en;
  logic [2:0] rf_wr_addr;
  logic [7:0] rf_wr_data;
  logic       br_valid;
  logic       br_taken;
  logic [7:0] br_target;
  logic       wrap;
  logic       done;

  reg_branch_unit #(.W(8), .AW(3)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op(op), .op_reg(op_reg),
    .op_v(op_v), .pc_in(pc_in),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
    .wrap(wrap), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side register file with a one-cycle registered read, plus a preload port.
  logic [7:0] rf [8];
  logic       pre_en;
  logic [2:0] pre_addr;
  logic [7:0] pre_data;

  always @(posedge clk) begin
    if (rf_rd_en) rf_rd_data <= rf[rf_rd_addr];
    if (pre_en) rf[pre_addr] <= pre_data;
    else if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
  end

  int mdl [8];
  int n_checks = 0;
  int n_fail   = 0;

  logic       a_done, a_wr_en, a_wrap, a_br_valid, a_taken;
  logic [2:0] a_wr_addr;
  logic [7:0] a_wr_data, a_target;

  typedef struct {
    logic [1:0] op;
    logic [2:0] r;
    logic [2:0] v;
    logic [7:0] pc;
    logic [7:0] x;
    logic [7:0] e_data;
    logic       e_wrap;
    logic       e_taken;
    logic [7:0] e_target;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_reg(input logic [2:0] a, input logic [7:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    mdl[a]   = int'(d);
    @(posedge clk);
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Called at a negedge with the unit idle; returns at the negedge after the op retires.
  // With noise set, op_valid stays asserted with a different op while the unit is busy.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [2:0] r,
                        input logic [2:0] v, input logic [7:0] pc, input bit noise);
    check({tag, "_ready_idle"}, 32'(op_ready), 32'd1);
    op_valid = 1'b1; op = o; op_reg = r; op_v = v; pc_in = pc;
    @(negedge clk);
    check({tag, "_rd_en"}, 32'(rf_rd_en), 32'd1);
    check({tag, "_rd_addr"}, 32'(rf_rd_addr), 32'(r));
    check({tag, "_ready_busy"}, 32'(op_ready), 32'd0);
    op_valid = noise; op = ~o; op_reg = r + 3'd1; op_v = ~v; pc_in = ~pc;
    @(negedge clk);
    check({tag, "_exec_quiet"}, 32'({done, rf_wr_en, br_valid, rf_rd_en}), 32'd0);
    @(negedge clk);
    a_done = done; a_wr_en = rf_wr_en; a_wr_addr = rf_wr_addr; a_wr_data = rf_wr_data;
    a_wrap = wrap; a_br_valid = br_valid; a_taken = br_taken; a_target = br_target;
    check({tag, "_done"}, 32'(a_done), 32'd1);
    check({tag, "_ready_done"}, 32'(op_ready), 32'd0);
    @(negedge clk);
    op_valid = 1'b0;
    check({tag, "_ready_back"}, 32'(op_ready), 32'd1);
    check({tag, "_idle_quiet"}, 32'({done, rf_wr_en, br_valid, rf_rd_en}), 32'd0);
    $display("%s op=%0d r=%0d v=%0d pc=%02h -> wr=%0b addr=%0d data=%02h wrap=%0b br=%0b taken=%0b tgt=%02h",
             tag, o, r, v, pc, a_wr_en, a_wr_addr, a_wr_data, a_wrap, a_br_valid, a_taken, a_target);
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op = '0; op_reg = '0; op_v = '0; pc_in = '0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0; rf_rd_data = '0;
    for (int i = 0; i < 8; i++) begin rf[i] = '0; mdl[i] = 0; end

    vecs[0] = '{2'b00, 3'd3, 3'd0, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{2'b01, 3'd1, 3'd0, 8'h00, 8'h05, 8'h04, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{2'b01, 3'd1, 3'd0, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 8'h00};
    vecs[3] = '{2'b10, 3'd2, 3'd5, 8'h20, 8'h00, 8'h00, 1'b0, 1'b1, 8'h2A};
    vecs[4] = '{2'b11, 3'd2, 3'd7, 8'hF8, 8'h00, 8'h00, 1'b0, 1'b0, 8'h06};
    vecs[5] = '{2'b11, 3'd2, 3'd7, 8'hF8, 8'h01, 8'h00, 1'b0, 1'b1, 8'h06};
    vecs[6] = '{2'b00, 3'd0, 3'd0, 8'h00, 8'h7F, 8'h80, 1'b0, 1'b0, 8'h00};
    vecs[7] = '{2'b10, 3'd6, 3'd0, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b0, 8'hFF};

    #2;
    check("rst_ready", 32'(op_ready), 32'd1);
    check("rst_outs", 32'({rf_rd_en, rf_rd_addr, rf_wr_en, rf_wr_addr, br_valid, br_taken, wrap, done}), 32'd0);
    check("rst_data", 32'({rf_wr_data, br_target}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      set_reg(vecs[i].r, vecs[i].x);
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].r, vecs[i].v, vecs[i].pc, 1'b0);
      if (vecs[i].op[1]) begin
        check($sformatf("vec%0d_wr_en", i), 32'(a_wr_en), 32'd0);
        check($sformatf("vec%0d_br_valid", i), 32'(a_br_valid), 32'd1);
        check($sformatf("vec%0d_taken", i), 32'(a_taken), 32'(vecs[i].e_taken));
        check($sformatf("vec%0d_target", i), 32'(a_target), 32'(vecs[i].e_target));
        check($sformatf("vec%0d_wrap", i), 32'(a_wrap), 32'd0);
      end else begin
        check($sformatf("vec%0d_wr_en", i), 32'(a_wr_en), 32'd1);
        check($sformatf("vec%0d_br_valid", i), 32'(a_br_valid), 32'd0);
        check($sformatf("vec%0d_wr_addr", i), 32'(a_wr_addr), 32'(vecs[i].r));
        check($sformatf("vec%0d_wr_data", i), 32'(a_wr_data), 32'(vecs[i].e_data));
        check($sformatf("vec%0d_wrap", i), 32'(a_wrap), 32'(vecs[i].e_wrap));
      end
    end

    // Back-to-back incr on r4 with op_valid held high throughout.
    set_reg(3'd4, 8'h10);
    op_valid = 1'b1; op = 2'b00; op_reg = 3'd4; op_v = '0; pc_in = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("b2b_k%0d_rd_en", k), 32'(rf_rd_en), 32'(k == 0 || k == 4));
      check($sformatf("b2b_k%0d_wr_en", k), 32'(rf_wr_en), 32'(k == 2 || k == 6));
      check($sformatf("b2b_k%0d_ready", k), 32'(op_ready), 32'(k == 3 || k == 7));
      if (k == 2) check("b2b_first_data", 32'(rf_wr_data), 32'h11);
      if (k == 6) check("b2b_second_data", 32'(rf_wr_data), 32'h12);
    end
    op_valid = 1'b0;
    mdl[4] = 'h12;
    $display("b2b incr r4 x2 -> data=%02h", rf_wr_data);

    // op_valid pulses while busy must not disturb the op in flight nor start a new one.
    set_reg(3'd6, 8'h40);
    run_op("noise", 2'b01, 3'd6, 3'd0, 8'h00, 1'b1);
    check("noise_wr_data", 32'(a_wr_data), 32'h3F);
    check("noise_wr_addr", 32'(a_wr_addr), 32'd6);
    mdl[6] = 'h3F;
    @(negedge clk);
    check("noise_no_extra_op", 32'(rf_rd_en), 32'd0);

    // Reset during EXEC of an incr aborts it with no write-back.
    set_reg(3'd5, 8'h33);
    op_valid = 1'b1; op = 2'b00; op_reg = 3'd5; op_v = '0; pc_in = '0;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_ready", 32'(op_ready), 32'd1);
    check("abort_outs", 32'({rf_rd_en, rf_wr_en, br_valid, br_taken, wrap, done}), 32'd0);
    check("abort_data", 32'({rf_wr_data, br_target, 2'b00, rf_wr_addr, rf_rd_addr}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("abort_k%0d_quiet", k), 32'({rf_wr_en, done, br_valid, rf_rd_en}), 32'd0);
    end
    check("abort_reg_kept", 32'(rf[5]), 32'h33);
    $display("abort incr r5 -> r5=%02h", rf[5]);

    // Random ops against the arithmetic model.
    for (int i = 0; i < 8; i++) set_reg(3'(i), 8'($urandom_range(0, 255)));
    set_reg(3'd7, 8'hFF);
    set_reg(3'd0, 8'h00);
    for (int t = 0; t < 150; t++) begin
      logic [1:0] ro;
      logic [2:0] rr, rv;
      logic [7:0] rpc;
      int x, e_data, e_target;
      bit e_wrap, e_taken;
      ro  = 2'($urandom_range(0, 3));
      rr  = 3'($urandom_range(0, 7));
      rv  = 3'($urandom_range(0, 7));
      rpc = 8'($urandom_range(0, 255));
      x = mdl[rr];
      e_data = 0; e_wrap = 0; e_taken = 0;
      e_target = (int'(rpc) + 2 * int'(rv)) % 256;
      case (ro)
        2'd0: begin e_data = (x + 1) % 256;   e_wrap = (x == 255); end
        2'd1: begin e_data = (x + 255) % 256; e_wrap = (x == 0);   end
        2'd2: e_taken = (x == 0);
        default: e_taken = (x != 0);
      endcase
      run_op($sformatf("rnd%0d", t), ro, rr, rv, rpc, bit'($urandom_range(0, 1)));
      if (ro[1]) begin
        check($sformatf("rnd%0d_br", t), 32'({a_br_valid, a_wr_en, a_wrap}), 32'b100);
        check($sformatf("rnd%0d_taken", t), 32'(a_taken), 32'(e_taken));
        check($sformatf("rnd%0d_target", t), 32'(a_target), 32'(e_target));
      end else begin
        mdl[rr] = e_data;
        check($sformatf("rnd%0d_wr", t), 32'({a_br_valid, a_wr_en}), 32'b01);
        check($sformatf("rnd%0d_addr", t), 32'(a_wr_addr), 32'(rr));
        check($sformatf("rnd%0d_data", t), 32'(a_wr_data), 32'(e_data));
        check($sformatf("rnd%0d_wrap", t), 32'(a_wrap), 32'(e_wrap));
      end
    end
    for (int i = 0; i < 8; i++) check($sformatf("final_r%0d", i), 32'(rf[i]), 32'(mdl[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
